fadd_accum_seq: RTL and testbench

Serial floating-point accumulation sequencer: the issuing side of the pipelined single-precision adder's Valid/Ready interface. It accepts a start command with a vector length, pulls IEEE 754 SP elements over a valid/ready stream, and issues one addition at a time to the adder (`Number1`/`Number2`/`Valid`). It captures each `Result` on the adder's `Ready` and returns the final sum. It sits between the control/convolution datapath and a single `Fadder` instance, and owns that adder exclusively.

---
 rtl/fadd_accum_seq.sv | 132 +++++++++++++
 tb/tb_fadd_accum_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_accum_seq.sv
// Serial SP accumulation sequencer: streams elements in, issues one add
// at a time to an external pipelined adder and returns the running sum.
module fadd_accum_seq #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [LEN_W-1:0] Len,
  input  logic             In_valid,
  input  logic [31:0]      In_data,
  output logic             In_ready,
  output logic             Add_valid,
  output logic [31:0]      Add_a,
  output logic [31:0]      Add_b,
  input  logic [31:0]      Add_result,
  input  logic             Add_ready,
  output logic [31:0]      Sum,
  output logic             Done,
  output logic             Busy,
  output logic             Err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_acc;
  logic [31:0]      r_operand;
  logic [LEN_W-1:0] r_rem;
  logic [CW-1:0]    r_wcnt;
  logic             r_err;
  logic             w_start;
  logic             w_hs;
  logic             w_tmo;

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_hs      = 1'b0;
    w_tmo     = 1'b0;
    In_ready  = 1'b0;
    Add_valid = 1'b0;
    Done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_start = 1'b1;
          w_next  = (Len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        In_ready = 1'b1;
        w_hs     = In_valid;
        if (In_valid)
          w_next = (r_rem == LEN_W'(1)) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        In_ready = 1'b1;
        w_hs     = In_valid;
        if (In_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        Add_valid = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (Add_ready) begin
          w_next = (r_rem == '0) ? S_DONE : S_FETCH;
        end else if (r_wcnt == CW'(TIMEOUT - 1)) begin
          w_tmo  = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // First element is loaded straight into acc; later ones go via operand.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_acc     <= '0;
      r_operand <= '0;
      r_rem     <= '0;
      r_wcnt    <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_start) begin
        r_rem <= Len;
        r_acc <= '0;
        r_err <= 1'b0;
      end
      if (w_hs) begin
        r_rem <= r_rem - LEN_W'(1);
        if (r_state == S_LOAD) r_acc     <= In_data;
        else                   r_operand <= In_data;
      end
      if (r_state == S_ISSUE) r_wcnt <= '0;
      if (r_state == S_WAIT) begin
        r_wcnt <= r_wcnt + CW'(1);
        if (Add_ready) r_acc <= Add_result;
      end
      if (w_tmo) r_err <= 1'b1;
    end
  end

  assign Add_a = r_acc;
  assign Add_b = r_operand;
  assign Sum   = r_acc;
  assign Err   = r_err;
  assign Busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_fadd_accum_seq.sv
// Bench for fadd_accum_seq: 4-cycle adder stub plus a cycle-level
// reference model of sums, issue cycles and Done timing.
module tb_fadd_accum_seq;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start;
  logic [7:0]  Len;
  logic        In_valid = 1'b0;
  logic [31:0] In_data = '0;
  logic        In_ready;
  logic        Add_valid;
  logic [31:0] Add_a;
  logic [31:0] Add_b;
  logic [31:0] Add_result;
  logic        Add_ready;
  logic [31:0] Sum;
  logic        Done;
  logic        Busy;
  logic        Err;

  logic        start_req = 1'b0;
  logic        glitch_req = 1'b0;
  logic [7:0]  cmd_len = '0;
  int          glitch_cyc = -1;
  int          cyc = 0;
  logic        stub_en = 1'b1;
  logic        mon_on = 1'b0;

  int          n_pass = 0;
  int          n_tot = 0;
  int          busy_from = 32'h7fffffff;
  int          exp_done = -1;
  logic [31:0] exp_sum = '0;
  logic [31:0] lit_sum = '0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_a [int];
  logic [31:0] exp_b [int];
  bit          zchk [int];
  bit          bchk [int];
  logic [31:0] el [0:255];

  assign Start = start_req | glitch_req;
  assign Len   = glitch_req ? 8'd2 : cmd_len;

  fadd_accum_seq dut (
    .Clk(clk), .Rst(Rst), .Start(Start), .Len(Len),
    .In_valid(In_valid), .In_data(In_data), .In_ready(In_ready),
    .Add_valid(Add_valid), .Add_a(Add_a), .Add_b(Add_b),
    .Add_result(Add_result), .Add_ready(Add_ready),
    .Sum(Sum), .Done(Done), .Busy(Busy), .Err(Err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) glitch_req = (cyc == glitch_cyc);

  function automatic real sp2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int          ee;
    if (r == 0.0) return 32'h0;
    d  = $realtobits(r);
    ee = int'(d[62:52]) - 1023 + 127;
    return {d[63], ee[7:0], d[51:29]};
  endfunction

  // Adder stub: Ready four cycles after Valid; result junk otherwise.
  logic [4:1]  r_v = '0;
  logic [31:0] r_r1, r_r2, r_r3, r_r4;
  always @(posedge clk) begin
    r_v  <= {r_v[3:1], Add_valid};
    r_r1 <= r2sp(sp2r(Add_a) + sp2r(Add_b));
    r_r2 <= r_r1;
    r_r3 <= r_r2;
    r_r4 <= r_r3;
  end
  assign Add_ready  = r_v[4] & stub_en;
  assign Add_result = r_v[4] ? r_r4 : 32'hDEADBEEF;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] want);
    n_tot++;
    if (act === want) n_pass++;
    else $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, want);
  endfunction

  // Single compare process, sampled 2 time units after each rising edge.
  always @(posedge clk) begin
    bit bz;
    #2;
    if (mon_on) begin
      bz = (cyc >= busy_from) && (cyc <= exp_done);
      chk("done", 32'(Done), 32'(cyc == exp_done));
      chk("busy", 32'(Busy), 32'(bz));
      chk("add_valid", 32'(Add_valid), 32'(exp_a.exists(cyc)));
      if (exp_a.exists(cyc)) begin
        chk("add_a", Add_a, exp_a[cyc]);
        chk("add_b", Add_b, exp_b[cyc]);
      end
      if (!bz) chk("in_ready_idle", 32'(In_ready), 32'h0);
      if (cyc == exp_done) begin
        chk("sum", Sum, exp_sum);
        chk("err", 32'(Err), 32'(exp_err));
        chk("in_ready_done", 32'(In_ready), 32'h0);
        chk("model_sum", exp_sum, lit_sum);
      end else if (cyc > exp_done) begin
        chk("sum_hold", Sum, exp_sum);
      end
      if (cyc == busy_from) chk("err_clear", 32'(Err), 32'h0);
    end
    if (zchk.exists(cyc)) begin
      chk("z_in_ready", 32'(In_ready), 32'h0);
      chk("z_add_valid", 32'(Add_valid), 32'h0);
      chk("z_add_a", Add_a, 32'h0);
      chk("z_add_b", Add_b, 32'h0);
      chk("z_sum", Sum, 32'h0);
      chk("z_done", 32'(Done), 32'h0);
      chk("z_busy", 32'(Busy), 32'h0);
      chk("z_err", 32'(Err), 32'h0);
    end
    if (bchk.exists(cyc)) begin
      chk("wait_busy", 32'(Busy), 32'h1);
      chk("wait_add_valid", 32'(Add_valid), 32'h0);
    end
  end

  task automatic run(input int len, input int stall1,
                     input logic [31:0] lit, input bit tmo,
                     input int gl_off);
    int  t0, prev, f, is, dn, k;
    real acc;
    @(negedge clk);
    t0  = cyc;
    acc = 0.0;
    if (len == 0) begin
      dn = t0 + 1;
    end else begin
      acc  = sp2r(el[0]);
      prev = t0 + 1;
      for (int j = 1; j < len; j++) begin
        f  = prev + 1 + ((j == 1) ? stall1 : 0);
        is = f + 1;
        exp_a[is] = r2sp(acc);
        exp_b[is] = el[j];
        if (tmo) begin
          prev = is + 15;
          break;
        end
        acc  = acc + sp2r(el[j]);
        prev = is + 4;
      end
      dn = prev + 1;
    end
    exp_sum    = r2sp(acc);
    lit_sum    = lit;
    exp_err    = tmo;
    busy_from  = t0 + 1;
    exp_done   = dn;
    glitch_cyc = (gl_off < 0) ? -1 : t0 + gl_off;
    start_req  = 1'b1;
    cmd_len    = 8'(len);
    @(negedge clk);
    start_req = 1'b0;
    for (int j = 0; j < len; j++) begin
      if (j == 1 && stall1 > 0) begin
        In_valid = 1'b0;
        repeat (stall1) @(negedge clk);
      end
      In_valid = 1'b1;
      In_data  = el[j];
      k = 0;
      while (!In_ready && k < 300) begin
        @(negedge clk);
        k++;
      end
      if (k >= 300) begin
        $display("FAIL drv_timeout element %0d", j);
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    In_valid = 1'b0;
    while (cyc < dn) @(negedge clk);
  endtask

  initial begin
    int t0;
    zchk[2] = 1'b1;
    zchk[3] = 1'b1;
    zchk[4] = 1'b1;
    repeat (4) @(negedge clk);
    Rst    = 1'b0;
    mon_on = 1'b1;

    run(0, 0, 32'h00000000, 1'b0, -1);
    el[0] = 32'h3F800000;
    run(1, 0, 32'h3F800000, 1'b0, -1);
    el[0] = 32'h3F800000; el[1] = 32'h40000000; el[2] = 32'h40400000;
    run(3, 0, 32'h40C00000, 1'b0, -1);
    el[0] = 32'h40A00000; el[1] = 32'hC0000000;
    run(2, 3, 32'h40400000, 1'b0, -1);
    el[0] = 32'h3F800000; el[1] = 32'h40000000; el[2] = 32'h40400000;
    run(3, 0, 32'h40C00000, 1'b0, 5);
    el[0] = 32'h3FC00000; el[1] = 32'h40200000;
    run(2, 0, 32'h40800000, 1'b0, 8);
    stub_en = 1'b0;
    el[0] = 32'h40A00000; el[1] = 32'h3F800000;
    run(2, 0, 32'h40A00000, 1'b1, -1);
    stub_en = 1'b1;
    el[0] = 32'hC0400000;
    run(1, 0, 32'hC0400000, 1'b0, -1);
    for (int i = 0; i < 256; i++) el[i] = 32'h3F800000;
    run(255, 0, 32'h437F0000, 1'b0, -1);

    // Reset in the second WAIT cycle; the late Ready must be ignored.
    @(negedge clk);
    mon_on = 1'b0;
    @(negedge clk);
    t0 = cyc;
    bchk[t0 + 5] = 1'b1;
    zchk[t0 + 6] = 1'b1;
    zchk[t0 + 8] = 1'b1;
    start_req = 1'b1;
    cmd_len   = 8'd2;
    In_valid  = 1'b1;
    In_data   = 32'h3F800000;
    @(negedge clk);
    start_req = 1'b0;
    @(negedge clk);
    In_data = 32'h40000000;
    @(negedge clk);
    In_valid = 1'b0;
    repeat (2) @(negedge clk);
    Rst = 1'b1;
    @(negedge clk);
    Rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
